keypad_scan: RTL and testbench

// Memory-mapped 4x4 matrix-keypad input device: the input counterpart of the CPU-written 7-segment display.

---
 rtl/keypad_scan_if.sv | 21 ++
 rtl/keypad_scan.sv | 230 +++++++++++++++++++++++
 tb/tb_keypad_scan.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_if.sv
// CPU bridge slot for the keypad device: word address, write/read strobes, data both ways, level irq.
// No flow control: reads are combinational, writes and pops complete on the strobed clock edge.
// The master drives address/strobes/write data; the slave returns read data and irq.
interface keypad_scan_if;
    logic [2:0]  Addr;
    logic        enable;
    logic        rd_en;
    logic [31:0] data_in;
    logic [31:0] data_return_cpu;
    logic        irq;

    modport master (
        output Addr, enable, rd_en, data_in,
        input  data_return_cpu, irq
    );

    modport slave (
        input  Addr, enable, rd_en, data_in,
        output data_return_cpu, irq
    );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: column scan, frame-level debounce, 4-deep key-code FIFO read over the CPU slot.
// Latency: one debounce decision per 4*SCAN_DIV-cycle frame; the accepted code lands in the FIFO 2 cycles after the last column sample.
// Backpressure: none; a press arriving with the FIFO full is dropped and latches a sticky overflow flag.
module keypad_scan #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic               clk,
    input  logic               reset,
    output logic [3:0]         col_out,
    input  logic [3:0]         row_in,
    keypad_scan_if.slave       bus
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE);

    typedef enum logic {IDLE, HELD} state_t;

    // scan state
    logic             started;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       column;
    logic [3:0]       row_meta;
    logic [3:0]       row_sync;
    logic [15:0]      snap;
    logic             frame_done;

    // key fsm state
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             prev_single;
    logic [3:0]       prev_key;
    logic             push_vld;
    logic [3:0]       push_dat;

    // fifo and registers
    logic [3:0]       mem [4];
    logic [1:0]       rd_ptr;
    logic [1:0]       wr_ptr;
    logic [2:0]       level;
    logic             ovf;
    logic             irq_en;
    logic             irq_q;

    // frame decode
    logic [4:0]       n_keys;
    logic [3:0]       key_idx;
    logic             single;
    logic             same_key;
    logic [CNT_W-1:0] cnt_plus;
    logic [CNT_W-1:0] cnt_idle;

    // bus decode
    logic             key_vld;
    logic             pop;
    logic             ctrl_wr;
    logic             flush;
    logic             ovf_clr;
    logic             ovf_set;
    logic             do_push;
    logic [31:0]      rd_dat;
    logic             unused_dat;

    assign unused_dat = ^bus.data_in[31:3];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
        end
    end

    // Column c is sampled on the last cycle of its own window; frame_done marks the cycle after column 3.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            started    <= 1'b0;
            col_out    <= 4'b1111;
            div_cnt    <= '0;
            column     <= 2'd0;
            snap       <= '0;
            frame_done <= 1'b0;
        end else if (!started) begin
            started    <= 1'b1;
            col_out    <= 4'b1110;
            div_cnt    <= '0;
            column     <= 2'd0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (div_cnt == DIV_LAST) begin
                div_cnt    <= '0;
                column     <= column + 2'd1;
                col_out    <= ~(4'b0001 << (column + 2'd1));
                frame_done <= (column == 2'd3);
                for (int r = 0; r < 4; r++) begin
                    snap[4*r + int'(column)] <= ~row_sync[r];
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        n_keys  = '0;
        key_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (snap[i]) begin
                n_keys  = n_keys + 5'd1;
                key_idx = 4'(i);
            end
        end
        single   = (n_keys == 5'd1);
        same_key = single && prev_single && (key_idx == prev_key);
        cnt_plus = cnt + 1'b1;
        cnt_idle = same_key ? cnt_plus : CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            prev_single <= 1'b0;
            prev_key    <= 4'd0;
            push_vld    <= 1'b0;
            push_dat    <= 4'd0;
        end else begin
            push_vld <= 1'b0;
            if (frame_done) begin
                prev_single <= single;
                prev_key    <= key_idx;
                case (state)
                    IDLE: begin
                        if (!single) begin
                            cnt <= '0;
                        end else if (cnt_idle == DEB_MAX) begin
                            push_vld <= 1'b1;
                            push_dat <= key_idx;
                            state    <= HELD;
                            cnt      <= '0;
                        end else begin
                            cnt <= cnt_idle;
                        end
                    end
                    HELD: begin
                        // any key during a hold restarts the release count; nothing repeats
                        if (n_keys != 5'd0) begin
                            cnt <= '0;
                        end else if (cnt_plus == DEB_MAX) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt_plus;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign key_vld = (level != 3'd0);
    assign pop     = bus.rd_en && (bus.Addr == 3'b000) && key_vld;
    assign ctrl_wr = bus.enable && (bus.Addr == 3'b010);
    assign flush   = ctrl_wr && bus.data_in[2];
    assign ovf_clr = ctrl_wr && bus.data_in[1];
    assign ovf_set = push_vld && (level == 3'd4) && !pop && !flush;
    assign do_push = push_vld && ((level != 3'd4) || pop);

    // Flush beats push and pop; a push into a full FIFO survives only alongside a pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                mem[i] <= 4'd0;
            end
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            level  <= 3'd0;
            ovf    <= 1'b0;
            irq_en <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            irq_q <= irq_en && key_vld;
            if (ctrl_wr) begin
                irq_en <= bus.data_in[0];
            end
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
            if (flush) begin
                rd_ptr <= 2'd0;
                wr_ptr <= 2'd0;
                level  <= 3'd0;
            end else begin
                if (do_push) begin
                    mem[wr_ptr] <= push_dat;
                    wr_ptr      <= wr_ptr + 2'd1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 2'd1;
                end
                level <= level + {2'b0, do_push} - {2'b0, pop};
            end
        end
    end

    always_comb begin
        rd_dat = '0;
        case (bus.Addr)
            3'b000:  rd_dat = {27'b0, key_vld, key_vld ? mem[rd_ptr] : 4'd0};
            3'b001:  rd_dat = {27'b0, irq_en, ovf, level};
            3'b010:  rd_dat = {31'b0, irq_en};
            default: rd_dat = '0;
        endcase
    end

    assign bus.data_return_cpu = rd_dat;
    assign bus.irq             = irq_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a behavioural key matrix; SCAN_DIV=4, DEBOUNCE=2 (16-cycle frames).
// Latency: expected values are hand-derived cycle counts from reset release or from the column-3 sample edge.
// Backpressure: exercises FIFO overflow, flush-free drain, and push+pop while full.
module tb_keypad_scan;
    logic        clk;
    logic        reset;
    logic [3:0]  col_out;
    logic [3:0]  row_in;
    logic [15:0] keys;
    logic [31:0] d;
    logic        found;
    int          n_checks;
    int          n_fail;

    keypad_scan_if bus ();

    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .col_out (col_out),
        .row_in  (row_in),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // key at row r, column c pulls row r low while column c is driven low
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4 + c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic peek(input logic [2:0] a, output logic [31:0] v);
        @(posedge clk); #1;
        bus.Addr = a;
        @(negedge clk);
        v = bus.data_return_cpu;
    endtask

    task automatic pop_key(output logic [31:0] v);
        @(posedge clk); #1;
        bus.Addr  = 3'b000;
        bus.rd_en = 1'b1;
        @(negedge clk);
        v = bus.data_return_cpu;
        @(posedge clk); #1;
        bus.rd_en = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] v);
        @(posedge clk); #1;
        bus.Addr    = a;
        bus.data_in = v;
        bus.enable  = 1'b1;
        @(posedge clk); #1;
        bus.enable  = 1'b0;
        bus.data_in = '0;
    endtask

    // hold a set of keys for a number of frames, then release and let the FSM settle for 3 frames
    task automatic hold(input logic [15:0] k, input int frames);
        keys = k;
        repeat (frames*16) @(posedge clk);
        #1 keys = '0;
        repeat (48) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        keys     = '0;
        reset    = 1'b0;
        bus.Addr = 3'b001;
        bus.enable  = 1'b0;
        bus.rd_en   = 1'b0;
        bus.data_in = '0;

        // 1: reset state and column sequence
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_col", {28'b0, col_out}, 32'hF);
        check("rst_irq", {31'b0, bus.irq}, 32'h0);
        check("rst_status", bus.data_return_cpu, 32'h0);
        reset = 1'b1;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            check($sformatf("scan_col%0d", n), {28'b0, col_out}, {28'b0, ~(4'b0001 << (n/4))});
        end

        // 2: r2c1 held 4 frames gives one 0x19; re-press gives a second
        hold(16'h0001 << 9, 4);
        peek(3'b001, d); check("t2_level1", d, 32'h01);
        peek(3'b000, d); check("t2_peek", d, 32'h19);
        hold(16'h0001 << 9, 2);
        peek(3'b001, d); check("t2_level2", d, 32'h02);
        pop_key(d); check("t2_pop1", d, 32'h19);
        pop_key(d); check("t2_pop2", d, 32'h19);
        peek(3'b001, d); check("t2_empty", d, 32'h00);

        // 3: short press and two-key ghost are rejected
        hold(16'h0001 << 0, 1);
        peek(3'b001, d); check("t3_short", d, 32'h00);
        hold((16'h0001 << 5) | (16'h0001 << 14), 5);
        peek(3'b001, d); check("t3_ghost", d, 32'h00);

        // 4: overflow on the fifth press, oldest-first drain, ovf clear
        for (int k = 1; k <= 5; k++) hold(16'h0001 << k, 2);
        peek(3'b001, d); check("t4_status", d, 32'h0C);
        for (int k = 1; k <= 4; k++) begin
            pop_key(d); check($sformatf("t4_pop%0d", k), d, 32'h10 | k);
        end
        peek(3'b000, d); check("t4_empty_key", d, 32'h00);
        wr(3'b010, 32'h2);
        peek(3'b001, d); check("t4_ovf_clr", d, 32'h00);

        // 5: irq follows the level one cycle late
        wr(3'b010, 32'h1);
        peek(3'b010, d); check("t5_ctrl_rd", d, 32'h01);
        bus.Addr = 3'b001;
        keys = 16'h0001 << 6;
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            if (bus.data_return_cpu[2:0] == 3'd1) found = 1'b1;
        end
        check("t5_push_seen", {31'b0, found}, 32'h1);
        check("t5_irq_before", {31'b0, bus.irq}, 32'h0);
        @(negedge clk);
        check("t5_irq_set", {31'b0, bus.irq}, 32'h1);
        hold(16'h0001 << 6, 1);
        pop_key(d); check("t5_pop", d, 32'h16);
        bus.Addr = 3'b001;
        @(negedge clk);
        check("t5_level0", bus.data_return_cpu, 32'h10);
        check("t5_irq_lag", {31'b0, bus.irq}, 32'h1);
        @(negedge clk);
        check("t5_irq_clr", {31'b0, bus.irq}, 32'h0);

        // 6: reset mid-debounce with level 3, then full push+pop
        hold(16'h0001 << 7, 2);
        hold(16'h0001 << 8, 2);
        hold(16'h0001 << 10, 2);
        peek(3'b001, d); check("t6_pre_status", d, 32'h13);
        keys = 16'h0001 << 0;
        repeat (20) @(posedge clk);
        #3 reset = 1'b0;
        @(negedge clk);
        check("t6_rst_col", {28'b0, col_out}, 32'hF);
        check("t6_rst_irq", {31'b0, bus.irq}, 32'h0);
        check("t6_rst_status", bus.data_return_cpu, 32'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("t6_one_frame", bus.data_return_cpu, 32'h00);
        repeat (16) @(posedge clk);
        @(negedge clk);
        check("t6_two_frames", bus.data_return_cpu, 32'h01);
        #6 keys = '0;
        repeat (48) @(posedge clk);
        for (int k = 11; k <= 13; k++) hold(16'h0001 << k, 2);
        peek(3'b001, d); check("t6_full", d, 32'h04);

        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (col_out == 4'b0111) found = 1'b1;
        end
        check("t6_sync_c3", {31'b0, found}, 32'h1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (col_out == 4'b1110) found = 1'b1;
        end
        check("t6_sync_c0", {31'b0, found}, 32'h1);
        keys = 16'h0001 << 14;
        repeat (33) @(posedge clk);
        #1;
        bus.Addr  = 3'b000;
        bus.rd_en = 1'b1;
        @(negedge clk);
        check("t6_pp_head", bus.data_return_cpu, 32'h10);
        @(posedge clk); #1;
        bus.rd_en = 1'b0;
        peek(3'b001, d); check("t6_pp_status", d, 32'h04);
        #1 keys = '0;
        repeat (48) @(posedge clk);
        for (int k = 11; k <= 14; k++) begin
            pop_key(d); check($sformatf("t6_drain%0d", k), d, 32'h10 | k);
        end
        peek(3'b001, d); check("t6_final", d, 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
